// File: rtl/ip_fetch_queue_pkg.sv
// Shared types and helpers for the N-way instruction fetch queue.
package ip_fetch_queue_pkg;

    localparam int IP_FETCH_WAYS_MAX = 8;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instr;
    } fetch_entry_t;

    // Length of the run of hits starting at port 0; a hit after a miss is not counted.
    function automatic logic [3:0] hit_prefix_len(input logic [IP_FETCH_WAYS_MAX-1:0] hits);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int k = 0; k < IP_FETCH_WAYS_MAX; k++) begin
            if (run && hits[k]) n = n + 4'd1;
            else                run = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/ip_fetch_queue_if.sv
// Clock/reset bundle and the cache/decoder-side bus of the fetch queue.
interface IntfCSB;
    logic clk;
    logic reset;

    modport master (output clk, output reset);
    modport slave  (input clk, input reset);
endinterface

interface ip_fetch_queue_if #(
    parameter int WAYS = 2
);
    logic [WAYS-1:0][31:0] i_cache_instr;
    logic [WAYS-1:0]       i_cache_hit;
    logic [WAYS-1:0][31:0] o_cache_address;
    logic [WAYS-1:0]       o_cache_read;
    logic [31:0]           i_jmp_address;
    logic                  i_jmp_write;
    logic                  i_halt;
    logic [WAYS-1:0][31:0] o_address;
    logic [WAYS-1:0][31:0] o_instr;
    logic [WAYS-1:0]       o_valid;
    logic                  o_empty;
    logic                  o_full;

    modport master (
        output i_cache_instr, i_cache_hit, i_jmp_address, i_jmp_write, i_halt,
        input  o_cache_address, o_cache_read, o_address, o_instr, o_valid, o_empty, o_full
    );

    modport slave (
        input  i_cache_instr, i_cache_hit, i_jmp_address, i_jmp_write, i_halt,
        output o_cache_address, o_cache_read, o_address, o_instr, o_valid, o_empty, o_full
    );
endinterface

// File: rtl/ip_fetch_ring.sv
// Multi-push / multi-pop circular buffer; owns head, tail and count.
module ip_fetch_ring
    import ip_fetch_queue_pkg::*;
#(
    parameter int  WAYS  = 2,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int NPW   = $clog2(WAYS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  fetch_entry_t    i_push_data [WAYS],
    input  logic [NPW-1:0]  i_n_push,
    input  logic            i_pop_en,
    output fetch_entry_t    o_data [WAYS],
    output logic [WAYS-1:0] o_valid,
    output logic [CW-1:0]   o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_n_pop;

    // All presented slots leave together; a partial pop is never taken.
    always_comb begin
        w_n_pop = '0;
        if (i_pop_en) w_n_pop = (int'(r_count) < WAYS) ? r_count : CW'(WAYS);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(i_n_push);
            r_head  <= r_head + AW'(w_n_pop);
            r_count <= r_count + CW'(i_n_push) - w_n_pop;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < WAYS; k++) begin
            if (NPW'(k) < i_n_push) r_mem[r_tail + AW'(k)] <= i_push_data[k];
        end
    end

    for (genvar k = 0; k < WAYS; k++) begin : g_present
        assign o_data[k]  = r_mem[r_head + AW'(k)];
        assign o_valid[k] = int'(r_count) > k;
    end

    assign o_count = r_count;

endmodule

// File: rtl/ip_fetch_queue.sv
// N-way fetch front end: drives WAYS cache ports, accepts the hit prefix, buffers in a ring.
// Optional IP_FETCH_STATS_EN adds fetched/miss/full event counters.
module ip_fetch_queue
    import ip_fetch_queue_pkg::*;
#(
    parameter int          WAYS         = 2,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    IntfCSB.slave           cs,
    ip_fetch_queue_if.slave bus
`ifdef IP_FETCH_STATS_EN
    ,
    output logic [31:0]     o_stat_fetched,
    output logic [31:0]     o_stat_miss,
    output logic [31:0]     o_stat_full
`endif
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int NPW = $clog2(WAYS + 1);

    logic [31:0]                  r_pc;
    logic [CW-1:0]                w_count;
    logic                         w_fetch;
    logic [NPW-1:0]               w_n_push;
    logic [IP_FETCH_WAYS_MAX-1:0] w_hits_ext;
    fetch_entry_t                 w_push_data [WAYS];
    fetch_entry_t                 w_pres [WAYS];
    logic [WAYS-1:0]              w_valid;
    logic                         w_unused_jmp_lsbs;

    // Space is judged on the registered count; same-cycle pops are not credited.
    assign w_fetch    = !cs.reset && !bus.i_jmp_write && ((DEPTH - int'(w_count)) >= WAYS);
    assign w_hits_ext = IP_FETCH_WAYS_MAX'(bus.i_cache_hit);
    assign w_n_push   = w_fetch ? NPW'(hit_prefix_len(w_hits_ext)) : '0;

    assign bus.o_cache_read = {WAYS{w_fetch}};

    for (genvar k = 0; k < WAYS; k++) begin : g_port
        assign bus.o_cache_address[k] = r_pc + 32'(4 * k);
        assign w_push_data[k]         = '{address: r_pc + 32'(4 * k), instr: bus.i_cache_instr[k]};
        assign bus.o_address[k]       = w_pres[k].address;
        assign bus.o_instr[k]         = w_pres[k].instr;
    end

    always_ff @(posedge cs.clk) begin
        if (cs.reset)             r_pc <= {RESET_VECTOR[31:2], 2'b00};
        else if (bus.i_jmp_write) r_pc <= {bus.i_jmp_address[31:2], 2'b00};
        else                      r_pc <= r_pc + (32'(w_n_push) << 2);
    end

    ip_fetch_ring #(
        .WAYS  (WAYS),
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk       (cs.clk),
        .i_reset     (cs.reset),
        .i_flush     (bus.i_jmp_write),
        .i_push_data (w_push_data),
        .i_n_push    (w_n_push),
        .i_pop_en    (!bus.i_halt),
        .o_data      (w_pres),
        .o_valid     (w_valid),
        .o_count     (w_count)
    );

    assign bus.o_valid = w_valid;
    assign bus.o_empty = (w_count == '0);
    assign bus.o_full  = int'(w_count) > (DEPTH - WAYS);

    assign w_unused_jmp_lsbs = &{1'b0, bus.i_jmp_address[1:0]};

`ifdef IP_FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_miss;
    logic [31:0] r_stat_full;

    // Jumps deliberately leave the counters running.
    always_ff @(posedge cs.clk) begin
        if (cs.reset) begin
            r_stat_fetched <= '0;
            r_stat_miss    <= '0;
            r_stat_full    <= '0;
        end else begin
            r_stat_fetched <= r_stat_fetched + 32'(w_n_push);
            if (w_fetch && !bus.i_cache_hit[0])  r_stat_miss <= r_stat_miss + 32'd1;
            if (!w_fetch && !bus.i_jmp_write)    r_stat_full <= r_stat_full + 32'd1;
        end
    end

    assign o_stat_fetched = r_stat_fetched;
    assign o_stat_miss    = r_stat_miss;
    assign o_stat_full    = r_stat_full;
`endif

endmodule

// File: doc/ip_fetch_queue.md
# ip_fetch_queue

N-way instruction fetch front end that generalises the fixed two-way loader of the instruction processor: it drives `WAYS` cache read ports per cycle, accepts the in-order prefix of hits, and buffers instructions in a `DEPTH`-entry ring. It presents up to `WAYS` instructions per cycle to the decoders and is redirected by jumps. It sits between the instruction cache and the decoder stage inside the instruction processor wrapper.

## Interface
- `WAYS`, 2: fetch and issue width, in instructions per cycle; range 1..8.
- `DEPTH`, 8: ring entries; must be a power of two and at least `2*WAYS`.
- `RESET_VECTOR`, 32'h0: program counter value after reset.
- `cs`  in  IntfCSB  carries the clock `cs.clk` and reset `cs.reset`. One clock; reset is synchronous and active-high.
- `i_cache_instr`  in  32 x `WAYS`  instruction words returned by the cache in the same cycle.
- `i_cache_hit`  in  1 x `WAYS`  per-port hit.
- `o_cache_address`  out  32 x `WAYS`  `PC + 4*k` for port k.
- `o_cache_read`  out  1 x `WAYS`  read strobe; all bits are equal.
- `i_jmp_address`  in  32  redirect target.
- `i_jmp_write`  in  1  redirect strobe.
- `i_halt`  in  1  downstream stall; no pop while high.
- `o_address`  out  32 x `WAYS`  address of each presented instruction.
- `o_instr`  out  32 x `WAYS`  presented instruction.
- `o_valid`  out  1 x `WAYS`  presented slot k is valid.
- `o_empty`, `o_full`  out  1 each  `count==0` and `count>DEPTH-WAYS` respectively.

## Operation
- **State:**
  - `pc` (32 bits); bits [1:0] are always 0.
  - `head` and `tail` (log2 DEPTH bits each); they wrap modulo DEPTH.
  - `count` (0..DEPTH).
- **Fetch enable:** `fetch = !cs.reset && !i_jmp_write && (DEPTH-count >= WAYS)`. `count` is the registered value; pops in the same cycle are not credited.
- **Cache request:** `o_cache_read[k] = fetch`. `o_cache_address[k] = pc + 4*k`.
- **Accept:** `n_push` is the length of the leading run of `i_cache_hit` bits starting at port 0. A hit after a miss is discarded. Entries `{pc+4k, instr[k]}` for k < `n_push` are written at `tail+k`. Then `pc += 4*n_push` and `tail += n_push`.
- **Present:** `o_valid[k] = (k < count)`. Slot k shows entry `head+k`, read directly from registers.
- **Pop:** `n_pop = i_halt ? 0 : min(count, WAYS)`. Every valid slot is consumed together; there is no partial pop.
- **Count update:** `count <= count + n_push - n_pop`.
- **Jump:** `i_jmp_write` sets `pc <= {i_jmp_address[31:2], 2'b00}`, `head = tail = count = 0`. There is no push and no pop that cycle. Jump beats halt and fetch.
- **Reset:** sets `pc = RESET_VECTOR`, `head = tail = count = 0`, all `o_valid = 0`, all `o_cache_read = 0`. Reset beats jump. Reset during an outstanding fetch discards the cache data.
- **Address overflow:** `pc` arithmetic wraps modulo 2^32.

## Timing
- Cache access is combinational, so address and hit/data appear in the same cycle.
- Fetch-to-present latency is 1 cycle. An instruction accepted in cycle t is valid at the outputs in cycle t+1.
- Jump-to-first-valid is 2 cycles: jump in cycle t, fetch of the target in cycle t+1, present in cycle t+2.
- Throughput is `WAYS` per cycle when all ports hit and `i_halt` is low. With `DEPTH = 2*WAYS` and a one-cycle fetch-enable lag, steady state still sustains full rate.
- Outputs are register-driven, except `o_cache_read` and `o_cache_address`, which are combinational from `pc`, `count` and `i_jmp_write`.

## Configuration
- `IP_FETCH_STATS_EN`, when defined, adds three output ports:
  - `o_stat_fetched` (32 bits): adds `n_push` each cycle.
  - `o_stat_miss` (32 bits): counts cycles with `fetch && !i_cache_hit[0]`.
  - `o_stat_full` (32 bits): counts cycles with `!fetch && !i_jmp_write && !cs.reset`.
- All three counters are cleared by reset, wrap at 2^32, and are not cleared by jumps.
- When the macro is undefined, these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- `pkg_defines` gains:
  - `fetch_entry_t`, a packed struct `{logic [31:0] address; logic [31:0] instr;}`.
  - `IP_FETCH_WAYS_MAX = 8`.
- Sub-module `ip_fetch_ring`: the multi-push/multi-pop circular buffer, parametrised by `WAYS` and `DEPTH`. It owns `head`, `tail` and `count`. The top level owns `pc`, fetch enable and the hit-prefix logic.

## Test plan
- **Reset fetch:** reset with `RESET_VECTOR = 0x100`, then all hits with `WAYS = 2`. Expect addresses 0x100/0x104. A cycle later `o_valid = 11` with addresses 0x100/0x104, and `pc = 0x108`.
- **Partial hit:** hit pattern `10`. Expect only 0x100 to be pushed, `pc = 0x104`. Pattern `01` pushes nothing and `pc` is unchanged.
- **Fill under halt:** `i_halt = 1`, all hits, `DEPTH = 8`, `WAYS = 2`. Expect `count` to go 2, 4, 6, 8, after which `o_cache_read = 0` and `o_full = 1`. Release the halt: 2 entries pop per cycle, in order, with correct wrap past entry 7.
- **Jump flush:** with `count = 5`, pulse `i_jmp_write` with target 0x2003 while `i_halt = 1`. Next cycle: `o_valid = 0`, `pc = 0x2000`. Two cycles later 0x2000/0x2004 are valid.
- **Reset mid-operation:** assert reset with `count = 6` and a hit in the same cycle. Next cycle: `count = 0`, `pc = RESET_VECTOR`, stats counters 0.
- **Stats:** with `IP_FETCH_STATS_EN` defined, run 10 cycles of all hits, `WAYS = 4`, no halt. Expect `o_stat_fetched = 40`, `o_stat_miss = 0`.
